pe_feeder: RTL

//  Sequencer that drives one parallel PE: reads neuron and weight chunks from two SRAMs,

---
 rtl/pe_feeder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pe_feeder.sv
// pe_feeder: sequences neuron/weight chunk reads from two SRAMs into one PE,
// marks the first/last chunk of every dot product, and tags each returned
// 32-bit result with its output-neuron index.
//
// Handshake: there is no ready signal anywhere on this block. A read issued
// (n_rd_en/w_rd_en high) in cycle t returns data in t+1, which is presented to
// the PE with pe_vld=1 in t+1. The PE answers with pe_vld_o two cycles after
// the issue of a last chunk. The consumer must take every res_vld cycle.
module pe_feeder #(
   parameter int DATA_W  = 512,
   parameter int NADDR_W = 8,
   parameter int WADDR_W = 12,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [CNT_W-1:0]   vec_len,
   input  logic [CNT_W-1:0]   out_num,
   output logic               busy,
   output logic               done,
   output logic               n_rd_en,
   output logic [NADDR_W-1:0] n_rd_addr,
   input  logic [DATA_W-1:0]  n_rd_data,
   output logic               w_rd_en,
   output logic [WADDR_W-1:0] w_rd_addr,
   input  logic [DATA_W-1:0]  w_rd_data,
   output logic [DATA_W-1:0]  pe_neuron,
   output logic [DATA_W-1:0]  pe_weight,
   output logic [1:0]         pe_ctl,
   output logic               pe_vld,
   input  logic [31:0]        pe_result,
   input  logic               pe_vld_o,
   output logic               res_vld,
   output logic [31:0]        res_data,
   output logic [CNT_W-1:0]   res_idx
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   vl_q;      // chunks per dot product
   logic [CNT_W-1:0]   on_q;      // results to collect (0 for an empty job)
   logic [CNT_W-1:0]   k_q;       // chunk index within the current output
   logic [CNT_W-1:0]   o_q;       // output-neuron index being issued
   logic [WADDR_W-1:0] w_addr_q;  // running weight address, o*vec_len+k
   logic [CNT_W-1:0]   res_idx_q;
   logic               pe_vld_q;
   logic [1:0]         pe_ctl_q;

   logic start_ok;
   logic job_empty;
   logic k_last;
   logic issue_last;
   logic res_all;
   logic running;

   assign start_ok   = (state_q == S_IDLE) && start;
   assign job_empty  = (vec_len == '0) || (out_num == '0);
   assign running    = (state_q == S_RUN);
   assign k_last     = (k_q == vl_q - ONE);
   assign issue_last = k_last && (o_q == on_q - ONE);
   // All results are in once the count has reached on_q, or the final one
   // arrives this cycle. The first term covers the empty job (on_q == 0).
   assign res_all    = (res_idx_q == on_q) ||
                       (pe_vld_o && (res_idx_q == on_q - ONE));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic. An empty job passes through DRAIN for one cycle, where
   // its zero-result count is already satisfied, so done lands two cycles
   // after start with no reads issued.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = job_empty ? S_DRAIN : S_RUN;
         S_RUN:   if (issue_last) state_d = S_DRAIN;
         S_DRAIN: if (res_all) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Job parameters and issue counters: latched on start, stepped per issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vl_q     <= '0;
         on_q     <= '0;
         k_q      <= '0;
         o_q      <= '0;
         w_addr_q <= '0;
      end else if (start_ok) begin
         vl_q     <= vec_len;
         on_q     <= job_empty ? '0 : out_num;
         k_q      <= '0;
         o_q      <= '0;
         w_addr_q <= '0;
      end else if (running) begin
         w_addr_q <= w_addr_q + {{(WADDR_W-1){1'b0}}, 1'b1};
         if (k_last) begin
            k_q <= '0;
            o_q <= o_q + ONE;
         end else begin
            k_q <= k_q + ONE;
         end
      end
   end

   // Result index: cleared on start, advanced after every result cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                                 res_idx_q <= '0;
      else if (start_ok)                                          res_idx_q <= '0;
      else if ((running || state_q == S_DRAIN) && pe_vld_o)       res_idx_q <= res_idx_q + ONE;
   end

   // PE valid/control delayed one cycle to line up with the SRAM read data;
   // control is zero whenever valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_vld_q <= 1'b0;
         pe_ctl_q <= 2'b00;
      end else begin
         pe_vld_q <= running;
         pe_ctl_q <= running ? {k_last, (k_q == '0)} : 2'b00;
      end
   end

   assign busy      = running || (state_q == S_DRAIN);
   assign done      = (state_q == S_DONE);
   assign n_rd_en   = running;
   assign w_rd_en   = running;
   assign n_rd_addr = NADDR_W'(k_q);
   assign w_rd_addr = w_addr_q;
   assign pe_neuron = n_rd_data;
   assign pe_weight = w_rd_data;
   assign pe_vld    = pe_vld_q;
   assign pe_ctl    = pe_ctl_q;
   assign res_vld   = pe_vld_o;
   assign res_data  = pe_result;
   assign res_idx   = res_idx_q;

endmodule
